// File: rtl/risc_tb_pkg.sv
// Shared RISC-V front-end definitions: instruction classes, base opcodes,
// and the opcode-to-class decoder used by the fetch buffer.
package risc_tb_pkg;

    typedef enum logic [2:0] {
        R_TYPE,
        I_TYPE,
        S_TYPE,
        B_TYPE,
        J_TYPE,
        UNKNOWN_TYPE
    } ins_type;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_J    = 7'b1101111;

    // Loads and JALR share the I-type immediate layout, so they classify as I.
    function automatic ins_type opcode_class(input logic [6:0] opcode);
        ins_type cls;
        case (opcode)
            OP_R:                     cls = R_TYPE;
            OP_I, OP_LOAD, OP_JALR:   cls = I_TYPE;
            OP_S:                     cls = S_TYPE;
            OP_B:                     cls = B_TYPE;
            OP_J:                     cls = J_TYPE;
            default:                  cls = UNKNOWN_TYPE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ifetch_buffer_fifo.sv
// In-order circular buffer holding fetched {pc, instruction} entries.
// Flush is synchronous and overrides push/pop in the same cycle.
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    // Pointers are exactly log2(DEPTH) bits, so wrap-around is free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // The upstream credit scheme must never let a push land on a full buffer.
    assert property (@(posedge clk) disable iff (rst)
        !(do_push && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction prefetch stage: issues sequential word fetches, buffers returned
// words with their PC, and hands them to decode; redirects flush and drop stale data.
module ifetch_buffer
    import risc_tb_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ins_valid,
    input  logic            ins_ready,
    output logic [31:0]     ins_data,
    output logic [XLEN-1:0] ins_pc,
    output ins_type         ins_class
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = XLEN + 32;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic [EW-1:0]   head;
    logic [XLEN-1:0] redirect_base;
    logic            req_fire;
    logic            rsp_push;
    logic            ins_pop;

    // Credit covers both buffered entries and requests whose data is still out.
    assign occupancy      = {1'b0, count} + {1'b0, inflight_q};
    assign imem_req_valid = !rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_push       = imem_rsp_valid && !redirect_valid && (drop_q == '0);
    assign ins_pop        = ins_valid && ins_ready && !redirect_valid;
    assign redirect_base  = redirect_pc & ~XLEN'(3);

    always_comb begin
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_base;
            rsp_pc_d   = redirect_base;
            drop_d     = inflight_d;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
            if (rsp_push) rsp_pc_d = rsp_pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    ifetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsp_push),
        .data_i  ({rsp_pc_q, imem_rsp_data}),
        .pop_i   (ins_pop),
        .flush_i (redirect_valid),
        .head_o  (head),
        .count_o (count)
    );

    assign ins_valid = (count != '0);
    assign ins_data  = head[31:0];
    assign ins_pc    = head[EW-1:32];
    assign ins_class = opcode_class(head[6:0]);

endmodule

// File: tb/tb_ifetch_buffer.sv
// Scoreboard bench for ifetch_buffer: a latency-configurable memory model feeds
// the DUT and every delivered instruction is checked against an expected queue.
module tb_ifetch_buffer;
    import risc_tb_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pendT;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entT;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic [31:0] reqAddr;
    logic        reqReady;
    logic        rspValid;
    logic [31:0] rspData;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        insValid;
    logic        insReady;
    logic [31:0] insData;
    logic [31:0] insPc;
    ins_type     insClass;

    pendT        pending[$];
    entT         expQ[$];
    logic [31:0] popLog[$];
    ins_type     classLog[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          memLat = 1;
    int          hsCount = 0;
    int          firstHsCyc = -1;
    int          firstValidCyc = -1;
    logic [31:0] expFetch = RESET_PC;
    logic [31:0] rspAddr = '0;
    int          rspTag = 0;

    ifetch_buffer #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (reqValid),
        .imem_req_addr  (reqAddr),
        .imem_req_ready (reqReady),
        .imem_rsp_valid (rspValid),
        .imem_rsp_data  (rspData),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .ins_valid      (insValid),
        .ins_ready      (insReady),
        .ins_data       (insData),
        .ins_pc         (insPc),
        .ins_class      (insClass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a fixed set of encodings covering every class, with the
    // address folded into the non-opcode bits except in the 0x200 window.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        logic [31:0] base;
        case (addr[4:2])
            3'd0: base = 32'h00A00093;
            3'd1: base = 32'h002081B3;
            3'd2: base = 32'hFE000EE3;
            3'd3: base = 32'hFFFFFFFF;
            3'd4: base = 32'h0000006F;
            3'd5: base = 32'h00112023;
            3'd6: base = 32'h00002083;
            default: base = 32'h000080E7;
        endcase
        if (addr[31:8] == 24'h000002) return base;
        return base ^ {addr[26:2], 7'b0};
    endfunction

    function automatic ins_type expClass(input logic [31:0] word);
        case (word[6:0])
            7'h33:             return R_TYPE;
            7'h13, 7'h03, 7'h67: return I_TYPE;
            7'h23:             return S_TYPE;
            7'h63:             return B_TYPE;
            7'h6F:             return J_TYPE;
            default:           return UNKNOWN_TYPE;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic memReady, input logic decReady,
                                 input logic redir, input logic [31:0] pc, input int n);
        reqReady      = memReady;
        insReady      = decReady;
        redirectValid = redir;
        redirectPc    = pc;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic resetDut();
        rst           = 1'b1;
        redirectValid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        firstHsCyc    = -1;
        firstValidCyc = -1;
        hsCount       = 0;
        popLog.delete();
        classLog.delete();
        rst = 1'b0;
    endtask

    // Memory response driver: returns requests in order once their latency expires.
    always @(posedge clk) begin : memDrive
        pendT p;
        #1;
        cyc++;
        if (rst) begin
            rspValid = 1'b0;
        end else if (pending.size() > 0 && pending[0].due <= cyc) begin
            p        = pending.pop_front();
            rspValid = 1'b1;
            rspData  = memWord(p.addr);
            rspAddr  = p.addr;
            rspTag   = p.epoch;
        end else begin
            rspValid = 1'b0;
        end
    end

    // Mid-cycle model update: decides what the coming clock edge must do.
    always @(negedge clk) begin : monitor
        entT e;
        int  occ;
        if (rst) begin
            checkOutput("rstInsValid", insValid, 0);
            checkOutput("rstReqValid", reqValid, 0);
            expQ.delete();
            pending.delete();
            expFetch = RESET_PC;
            epoch++;
        end else begin
            occ = expQ.size() + pending.size() + (rspValid ? 1 : 0);
            checkOutput("reqValid", reqValid, (!redirectValid && occ < DEPTH));
            checkOutput("insValid", insValid, (expQ.size() != 0));
            if (insValid && firstValidCyc < 0) firstValidCyc = cyc;
            if (insValid && insReady && !redirectValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("popUnexpected", insValid, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("insPc", insPc, e.pc);
                    checkOutput("insData", insData, e.data);
                    checkOutput("insClass", insClass, expClass(e.data));
                    popLog.push_back(insPc);
                    classLog.push_back(insClass);
                end
            end
            if (rspValid && !redirectValid && rspTag == epoch) begin
                expQ.push_back('{rspAddr, memWord(rspAddr)});
            end
            if (reqValid && reqReady) begin
                checkOutput("reqAddr", reqAddr, expFetch);
                pending.push_back('{reqAddr, epoch, cyc + memLat});
                expFetch = expFetch + 32'd4;
                hsCount++;
                if (firstHsCyc < 0) firstHsCyc = cyc;
            end
            if (redirectValid) begin
                epoch++;
                expQ.delete();
                expFetch = redirectPc & ~32'd3;
            end
        end
    end

    initial begin : stimulus
        int guard;
        rst           = 1'b1;
        reqReady      = 1'b1;
        insReady      = 1'b1;
        redirectValid = 1'b0;
        redirectPc    = '0;

        // Streaming with single-cycle memory and an always-ready decoder.
        memLat = 1;
        resetDut();
        applyStimulus(1, 1, 0, 32'h0, 20);
        checkOutput("firstLatency", firstValidCyc - firstHsCyc, 2);
        checkOutput("streamPops", (popLog.size() >= 6), 1);
        if (popLog.size() >= 6) begin
            checkOutput("streamPc0", popLog[0], 32'h0);
            checkOutput("streamPc5", popLog[5], 32'h14);
        end

        // Stalled decoder: credit stops fetching at DEPTH, then drains in order.
        insReady = 1'b0;
        resetDut();
        applyStimulus(1, 0, 0, 32'h0, 10);
        checkOutput("stallHandshakes", hsCount, DEPTH);
        checkOutput("stallReqValid", reqValid, 0);
        applyStimulus(1, 1, 0, 32'h0, 8);
        checkOutput("drainPops", (popLog.size() >= 4), 1);
        if (popLog.size() >= 4) begin
            for (int i = 0; i < 4; i++) checkOutput("drainPc", popLog[i], 32'(4 * i));
        end
        checkOutput("fetchResumed", (hsCount > DEPTH), 1);

        // Pre-decode classes from the 0x200 window.
        applyStimulus(1, 1, 1, 32'h200, 1);
        popLog.delete();
        classLog.delete();
        applyStimulus(1, 1, 0, 32'h0, 10);
        checkOutput("classPops", (classLog.size() >= 4), 1);
        if (classLog.size() >= 4) begin
            checkOutput("classPc0", popLog[0], 32'h200);
            checkOutput("classAddi", classLog[0], I_TYPE);
            checkOutput("classAdd", classLog[1], R_TYPE);
            checkOutput("classBranch", classLog[2], B_TYPE);
            checkOutput("classUnknown", classLog[3], UNKNOWN_TYPE);
        end

        // Three-cycle memory: two requests in flight when the redirect hits.
        memLat   = 3;
        reqReady = 1'b0;
        resetDut();
        applyStimulus(1, 1, 0, 32'h0, 2);
        applyStimulus(0, 1, 1, 32'h100, 1);
        popLog.delete();
        applyStimulus(1, 1, 0, 32'h0, 15);
        checkOutput("latRedirectPops", (popLog.size() >= 2), 1);
        if (popLog.size() >= 2) begin
            checkOutput("latRedirectPc0", popLog[0], 32'h100);
            checkOutput("latRedirectPc1", popLog[1], 32'h104);
        end

        // Redirect coinciding with a response and a pop, then a second redirect.
        memLat   = 1;
        insReady = 1'b0;
        resetDut();
        guard = 0;
        while (!(expQ.size() == 2 && rspValid) && guard < 20) begin
            applyStimulus(1, 0, 0, 32'h0, 1);
            guard++;
        end
        checkOutput("countTwoReached", (guard < 20), 1);
        applyStimulus(1, 1, 1, 32'h43, 1);
        checkOutput("flushInsValid", insValid, 0);
        applyStimulus(1, 1, 1, 32'h82, 1);
        popLog.delete();
        applyStimulus(1, 1, 0, 32'h0, 10);
        checkOutput("doubleRedirectPops", (popLog.size() >= 1), 1);
        if (popLog.size() >= 1) checkOutput("doubleRedirectPc", popLog[0], 32'h80);

        // Asynchronous reset while the buffer is full.
        insReady = 1'b0;
        guard = 0;
        while (expQ.size() != DEPTH && guard < 20) begin
            applyStimulus(1, 0, 0, 32'h0, 1);
            guard++;
        end
        checkOutput("fullReached", (guard < 20), 1);
        checkOutput("fullInsValid", insValid, 1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("asyncInsValid", insValid, 0);
        checkOutput("asyncReqValid", reqValid, 0);
        insReady = 1'b1;
        resetDut();
        applyStimulus(1, 1, 0, 32'h0, 10);
        checkOutput("restartPops", (popLog.size() >= 1), 1);
        if (popLog.size() >= 1) checkOutput("restartPc", popLog[0], RESET_PC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_buffer.md
Name: ifetch_buffer

Overview:
- Instruction fetch/prefetch stage directly upstream of the instruction decoder in the RISC-V single-cycle core.
- Generates sequential word fetches to instruction memory and buffers the returned words, each with its PC, in an in-order FIFO.
- Presents one instruction per cycle to decode through a valid/ready handshake, with a pre-decoded instruction class.
- Accepts PC redirects from branch/jump resolution: flushes buffered entries and discards stale in-flight responses.

Parameters:
- XLEN, 32, data and address width.
- DEPTH, 4, FIFO entries; power of two, range 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address, word aligned.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response word valid; responses are in order, at most one per cycle.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  one-cycle PC redirect pulse.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] are ignored and treated as 0.
- ins_valid  out  1  head entry valid.
- ins_ready  in  1  decoder consumes head.
- ins_data  out  32  head instruction.
- ins_pc  out  XLEN  head PC.
- ins_class  out  ins_type  pre-decoded class of head (R/I/B/J/S/UNKNOWN_TYPE).

Behaviour:
- Reset values while rst is asserted:
  - imem_req_valid=0, ins_valid=0; ins_data, ins_pc and ins_class are don't-care.
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO count=0, inflight=0, drop=0.
- Request credit: imem_req_valid = (count + inflight < DEPTH) && !redirect_valid.
- imem_req_addr = fetch_pc. It stays stable while valid and not ready, except in a redirect cycle, where the request may be withdrawn.
- Request handshake (valid && ready): fetch_pc += 4 (wraps modulo 2^XLEN) and inflight += 1.
- Response with drop>0: word discarded, drop -= 1, inflight -= 1.
- Response with drop==0: push {rsp_pc, data} into the FIFO, rsp_pc += 4, inflight -= 1.
  - No bypass: a response in cycle T gives ins_valid=1 in T+1.
  - Best-case latency from request handshake to ins_valid is 2 cycles with single-cycle memory.
- The credit rule guarantees a push never hits a full FIFO. Assertion: a push when count==DEPTH is an error.
- Pop on ins_valid && ins_ready. A simultaneous push and pop leaves count unchanged, including at count==DEPTH-1 and count==1.
- ins_class is combinational from the head opcode:
  - 0110011 → R
  - 0010011, 0000011, 1100111 → I
  - 0100011 → S
  - 1100011 → B
  - 1101111 → J
  - anything else → UNKNOWN_TYPE
- Redirect has priority over every other event in the same cycle. At that clock edge:
  - FIFO flushed: count=0, ins_valid=0 in the next cycle; a pop in the redirect cycle has no effect.
  - fetch_pc = rsp_pc = redirect_pc.
  - drop = inflight_next, i.e. inflight after applying this cycle's response; no request is issued this cycle.
  - A response arriving in the redirect cycle is discarded and not counted in drop.
- Back-to-back redirects: the last one wins; drop is recomputed each time.
- Reset mid-operation clears all state immediately. Memory responses returning after reset are not dropped; memory must be reset together with this block.
- Counter widths: count and inflight are $clog2(DEPTH)+1 bits. Neither can exceed DEPTH.

Decomposition:
- Shared package risc_tb_pkg provides:
  - the ins_type enum
  - opcode localparams OP_R=7'b0110011, OP_I=7'b0010011, OP_LOAD=7'b0000011, OP_JALR=7'b1100111, OP_S=7'b0100011, OP_B=7'b1100011, OP_J=7'b1101111
  - function opcode_class(opcode) returning ins_type
- One sub-module, ifetch_fifo:
  - parameterised width/depth circular buffer with push, pop, flush, count, head outputs
  - synchronous flush, asynchronous rst
  - wrap-around pointers of $clog2(DEPTH) bits

Test Plan:
- Reset release, memory always ready with 1-cycle latency, ins_ready=1:
  - requests to 0x0, 0x4, 0x8, …
  - first ins_valid 2 cycles after the first handshake, ins_pc=0x0
  - then one instruction per cycle with PC increasing by 4.
- ins_ready=0, memory always ready:
  - exactly DEPTH=4 requests issued, then imem_req_valid=0
  - FIFO holds PCs 0x0..0xC; raising ins_ready drains in order, and requests resume.
- Head word 32'h00A00093 (addi x1,x0,10) → ins_class=I. Word 32'h002081B3 → R. Word 32'hFE000EE3 → B. Word 32'hFFFFFFFF → UNKNOWN_TYPE.
- Memory latency 3, 2 requests in flight, redirect_pc=0x100:
  - both stale responses discarded
  - next ins_pc=0x100 with the data fetched from 0x100.
- Redirect coinciding with a response and a pop at count=2 → the next cycle has ins_valid=0 and the response is discarded. Redirects to 0x40 then 0x80 on consecutive cycles → the first delivered PC is 0x80.
- rst asserted asynchronously mid-stream with the FIFO full → ins_valid and imem_req_valid drop immediately. After release, fetching restarts at RESET_PC.
